// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction, writeback select,
// register-file write port and retired-instruction counter.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_regwrite,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_resultsrc,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pcplus4,
  input  logic [XLEN-1:0] in_readdata,
  output logic            we3,
  output logic [4:0]      wa3,
  output logic [XLEN-1:0] wd3,
  output logic            wb_valid,
  output logic            load_misaligned,
  output logic [63:0]     instret
);

  logic [1:0]      off;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_data;
  logic            mis_ld;
  logic            mis;
  logic [XLEN-1:0] wd_mux;

  logic            valid_q, valid_d;
  logic            we_q, we_d;
  logic [4:0]      wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            mis_q, mis_d;
  logic [63:0]     instret_q, instret_d;

  assign off = in_alu_result[1:0];

  always_comb begin
    unique case (off)
      2'd0: ld_b = in_readdata[7:0];
      2'd1: ld_b = in_readdata[15:8];
      2'd2: ld_b = in_readdata[23:16];
      2'd3: ld_b = in_readdata[31:24];
    endcase
    ld_h = off[1] ? in_readdata[31:16] : in_readdata[15:0];
  end

  // Byte loads can never be misaligned; word-class is the fallback.
  always_comb begin
    ld_data = in_readdata;
    mis_ld  = (off != 2'b00);
    unique case (in_funct3)
      3'b000: begin
        ld_data = {{24{ld_b[7]}}, ld_b};
        mis_ld  = 1'b0;
      end
      3'b100: begin
        ld_data = {24'd0, ld_b};
        mis_ld  = 1'b0;
      end
      3'b001: begin
        ld_data = {{16{ld_h[15]}}, ld_h};
        mis_ld  = off[0];
      end
      3'b101: begin
        ld_data = {16'd0, ld_h};
        mis_ld  = off[0];
      end
      default: ;
    endcase
  end

  assign mis = (in_resultsrc == 2'b01) & mis_ld;

  always_comb begin
    unique case (in_resultsrc)
      2'b01:   wd_mux = ld_data;
      2'b10:   wd_mux = in_pcplus4;
      default: wd_mux = in_alu_result;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    we_d      = we_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    mis_d     = mis_q;
    instret_d = instret_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      mis_d   = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      we_d    = in_valid & in_regwrite
              & (in_rd != 5'd0) & ~mis;
      wa_d    = in_rd;
      wd_d    = wd_mux;
      mis_d   = in_valid & mis;
      if (in_valid && !mis)
        instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      wa_q      <= 5'd0;
      wd_q      <= '0;
      mis_q     <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      valid_q   <= valid_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      mis_q     <= mis_d;
      instret_q <= instret_d;
    end
  end

  assign wb_valid        = valid_q;
  assign we3             = we_q;
  assign wa3             = wa_q;
  assign wd3             = wd_q;
  assign load_misaligned = mis_q;
  assign instret         = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases plus random traffic
// compared against a behavioural writeback model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, in_regwrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_resultsrc;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_pcplus4, in_readdata;
  logic        we3, wb_valid, load_misaligned;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;

  logic        e_valid, e_we, e_mis, e_known;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;
  logic [63:0] e_instret;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite),
    .in_rd(in_rd), .in_resultsrc(in_resultsrc),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_pcplus4(in_pcplus4), .in_readdata(in_readdata),
    .we3(we3), .wa3(wa3), .wd3(wd3), .wb_valid(wb_valid),
    .load_misaligned(load_misaligned), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(
      input logic [2:0] f3, input int off,
      input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (off * 8)) & 32'hFF);
    h = 16'((w >> ((off / 2) * 16)) & 32'hFFFF);
    case (f3)
      3'd0: return 32'($signed(b));
      3'd4: return 32'(b);
      3'd1: return 32'($signed(h));
      3'd5: return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic bit ref_mis(
      input logic [1:0] src, input logic [2:0] f3,
      input int off);
    if (src != 2'b01) return 1'b0;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
    return off != 0;
  endfunction

  task automatic model_edge();
    int  off;
    bit  m;
    off = int'(in_alu_result % 4);
    if (reset) begin
      e_valid = 0; e_we = 0; e_mis = 0;
      e_wa = 0; e_wd = 0; e_instret = 0; e_known = 1;
    end else if (flush) begin
      e_valid = 0; e_we = 0; e_mis = 0; e_known = 0;
    end else if (!stall) begin
      m = ref_mis(in_resultsrc, in_funct3, off);
      e_valid = in_valid;
      e_we = in_valid && in_regwrite && in_rd != 0 && !m;
      e_mis = in_valid && m;
      e_wa = in_rd;
      case (in_resultsrc)
        2'b01: e_wd = ref_load(in_funct3, off, in_readdata);
        2'b10: e_wd = in_pcplus4;
        default: e_wd = in_alu_result;
      endcase
      e_known = 1;
      if (in_valid && !m) e_instret = e_instret + 1;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(e_valid));
    chk({tag, ".we3"}, 64'(we3), 64'(e_we));
    chk({tag, ".mis"}, 64'(load_misaligned), 64'(e_mis));
    chk({tag, ".instret"}, instret, e_instret);
    if (e_known) begin
      chk({tag, ".wa3"}, 64'(wa3), 64'(e_wa));
      chk({tag, ".wd3"}, 64'(wd3), 64'(e_wd));
    end
  endtask

  task automatic drive(input logic v, input logic rw,
                       input logic [4:0] rd,
                       input logic [1:0] src,
                       input logic [2:0] f3,
                       input logic [31:0] alu,
                       input logic [31:0] pc4,
                       input logic [31:0] rdata);
    in_valid = v; in_regwrite = rw; in_rd = rd;
    in_resultsrc = src; in_funct3 = f3;
    in_alu_result = alu; in_pcplus4 = pc4;
    in_readdata = rdata;
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    e_valid = 0; e_we = 0; e_mis = 0; e_known = 0;
    e_wa = 0; e_wd = 0; e_instret = 0;
    reset = 1; stall = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("rst0");
    cycle("rst1");
    reset = 0;
    cycle("idle");

    drive(1, 1, 5'd5, 2'b00, 3'd0, 32'h1234_5678, 0, 0);
    cycle("alu_rd5");
    chk("alu_rd5.we3_lit", 64'(we3), 64'd1);
    chk("alu_rd5.wd3_lit", 64'(wd3), 64'h1234_5678);
    drive(1, 1, 5'd0, 2'b00, 3'd0, 32'hDEAD_BEEF, 0, 0);
    cycle("alu_rd0");
    chk("alu_rd0.instret_lit", instret, 64'd2);

    drive(1, 1, 5'd7, 2'b01, 3'd0, 32'd3, 0, RD);
    cycle("lb3");
    chk("lb3.lit", 64'(wd3), 64'hFFFF_FF80);
    drive(1, 1, 5'd7, 2'b01, 3'd4, 32'd3, 0, RD);
    cycle("lbu3");
    chk("lbu3.lit", 64'(wd3), 64'h0000_0080);
    drive(1, 1, 5'd7, 2'b01, 3'd1, 32'd2, 0, RD);
    cycle("lh2");
    chk("lh2.lit", 64'(wd3), 64'hFFFF_80FF);
    drive(1, 1, 5'd7, 2'b01, 3'd5, 32'd0, 0, RD);
    cycle("lhu0");
    chk("lhu0.lit", 64'(wd3), 64'h0000_7F01);
    drive(1, 1, 5'd7, 2'b01, 3'd2, 32'd0, 0, RD);
    cycle("lw0");
    chk("lw0.lit", 64'(wd3), 64'h80FF_7F01);

    drive(1, 1, 5'd8, 2'b01, 3'd2, 32'd2, 0, RD);
    cycle("lw2_mis");
    chk("lw2_mis.lit", 64'(load_misaligned), 64'd1);
    drive(1, 1, 5'd8, 2'b01, 3'd1, 32'd1, 0, RD);
    cycle("lh1_mis");
    chk("lh1_mis.we3_lit", 64'(we3), 64'd0);

    drive(1, 1, 5'd1, 2'b10, 3'd0, 32'h55, 32'h104, 0);
    cycle("jal");
    chk("jal.wd3_lit", 64'(wd3), 64'h104);
    stall = 1;
    drive(1, 1, 5'd9, 2'b00, 3'd0, 32'h99, 0, 0);
    for (int i = 0; i < 3; i++) cycle("stall");
    flush = 1;
    cycle("flush_stall");
    flush = 0; stall = 0;

    // Reset in the middle of a stall and of a flush.
    drive(1, 1, 5'd3, 2'b00, 3'd0, 32'h77, 0, 0);
    cycle("pre_rst");
    stall = 1; reset = 1;
    cycle("rst_stall");
    stall = 0; flush = 1;
    cycle("rst_flush");
    flush = 0; reset = 0;

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 8, 1'($urandom),
            5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom);
      stall = $urandom_range(0, 9) < 2;
      flush = $urandom_range(0, 9) < 1;
      reset = $urandom_range(0, 49) < 1;
      cycle("rand");
    end
    reset = 0; stall = 0; flush = 0;

    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    e_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1, 1, 5'd4, 2'b00, 3'd0, 32'h1, 0, 0);
    cycle("wrap");
    chk("wrap.lit", instret, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback logic of the five-stage RISC-V core. It sits directly upstream of the register file and drives its write port (we3/wa3/wd3). It captures MEM-stage results on the rising clock edge, so the register file commits them on the following falling edge. It also performs load byte/halfword extraction and sign/zero extension, selects the writeback source, blocks illegal writes, and keeps a 64-bit retired-instruction counter.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hold all stage state.
- flush  input  1  turn the incoming slot into a bubble.
- in_valid  input  1  MEM stage holds a real instruction.
- in_regwrite  input  1  instruction writes rd.
- in_rd  input  5  destination register index.
- in_resultsrc  input  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 ALU.
- in_funct3  input  3  load size/sign; meaningful only when in_resultsrc=01.
- in_alu_result  input  32  ALU result; bits [1:0] are the load byte offset.
- in_pcplus4  input  32  link value.
- in_readdata  input  32  raw aligned word from data memory, combinational in the MEM cycle.
- we3  output  1  register-file write enable.
- wa3  output  5  register-file write address.
- wd3  output  32  register-file write data.
- wb_valid  output  1  WB slot holds a real instruction.
- load_misaligned  output  1  WB instruction is a misaligned load; its write is suppressed.
- instret  output  64  count of retired instructions.

## Operation
- Next-state priority: reset > flush > stall > normal capture.
- **Load extraction**, combinational before the register. off = in_alu_result[1:0].
  - funct3 000 (lb): byte at off, sign-extended.
  - 100 (lbu): byte at off, zero-extended.
  - 001 (lh): halfword at off[1], sign-extended.
  - 101 (lhu): halfword at off[1], zero-extended.
  - 010 (lw) and 011/110/111: full word.
  - Little-endian: byte 0 is bits [7:0].
- **Misalignment**, evaluated only when in_resultsrc=01:
  - Halfword load (001/101) with off[0]=1 is misaligned.
  - Any word-class load with off≠0 is misaligned.
- **Write data**: wd3_next is the load data, PC+4 or ALU result per in_resultsrc.
- **Write enable**: we3_next = in_valid & in_regwrite & (in_rd≠0) & ~misaligned.
  - Writes to x0 are never issued.
- **Capture** (normal cycle): the stage registers wb_valid, we3, wa3, wd3 and load_misaligned.
  - load_misaligned_next = in_valid & misaligned.
- **Flush**: wb_valid, we3 and load_misaligned all become 0.
  - wa3 and wd3 may take any value but must not cause a write.
- **Stall**: all outputs hold.
  - A held we3=1 rewrites the same value to the same register; this is idempotent and intended.
- **instret**: increments by 1 on each rising edge where the stage captures with in_valid=1 and ~misaligned.
  - No increment while stalled, flushed or in reset, so a stalled instruction is counted exactly once.
  - Wraps from 2^64−1 to 0.
- **Reset values**: we3=0, wa3=0, wd3=0, wb_valid=0, load_misaligned=0, instret=0.

## Timing
- Latency is 1 cycle: MEM-stage inputs at posedge N appear on the outputs after posedge N.
- The register file commits at the falling edge inside cycle N+1.
- ID reads in the second half of cycle N+1 therefore see the new value, so no WB→ID bypass is needed.
- Outputs come straight from flops, with no combinational path from inputs to outputs.
- in_readdata must settle before posedge within the MEM cycle. This block adds extraction plus a 4:1 mux on that path.
- flush and stall both asserted: flush wins and a bubble is inserted.
- reset mid-stall or mid-flush: reset wins, and all outputs equal their reset values after the edge.

## Test plan
- Reset held 2 cycles, then released with in_valid=0 → all outputs 0, instret=0.
- ALU write of rd=5, ALU result 0x1234_5678 → next cycle we3=1, wa3=5, wd3=0x1234_5678, instret=1; a rd=0 variant gives we3=0 with instret still incrementing.
- in_readdata=0x80FF_7F01, load variants:
  - lb at off=3 → wd3=0xFFFF_FF80.
  - lbu at off=3 → wd3=0x0000_0080.
  - lh at off=2 → wd3=0xFFFF_80FF.
  - lhu at off=0 → wd3=0x0000_7F01.
  - lw at off=0 → wd3=0x80FF_7F01.
- lw at off=2 and lh at off=1 → we3=0, load_misaligned=1, wb_valid=1, instret unchanged.
- JAL case: in_resultsrc=10, in_pcplus4=0x104, rd=1 → wd3=0x104.
  - Then stall for 3 cycles → outputs hold and instret increments only once.
  - Then flush together with stall → wb_valid=0, we3=0.
- instret preloaded to 0xFFFF_FFFF_FFFF_FFFF via a forced value, then one valid instruction → instret=0.
